// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : Instruction-fetch stage. Owns the program counter, drives the
//               instruction-memory address and registers the fetched word
//               into the IF/ID pipeline register. Honours stall, flush and
//               redirect requests and counts accepted fetches.
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        reset_i,          // synchronous, active-low
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  output logic        id_valid_o,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_pc4_o,
  output logic [31:0] fetch_count_o
);

  localparam logic [31:0] c_PC_STEP    = 32'd4;
  localparam logic [31:0] c_ALIGN_MASK = 32'hFFFF_FFFC;

  // Architectural state
  logic [31:0] pc_q,          pc_d;
  logic        id_valid_q,    id_valid_d;
  logic [31:0] id_instr_q,    id_instr_d;
  logic [31:0] id_pc_q,       id_pc_d;
  logic [31:0] id_pc4_q,      id_pc4_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  // Shared helpers
  logic [31:0] w_pc_plus4;
  logic [31:0] w_redirect_aligned;
  logic        w_kill;   // current fetch is wrong-path or flushed
  logic        w_load;   // current fetch is accepted into IF/ID

  assign w_pc_plus4         = pc_q + c_PC_STEP;             // wraps mod 2^32
  assign w_redirect_aligned = redirect_pc_i & c_ALIGN_MASK; // word-align target
  assign w_kill             = flush_i | redirect_valid_i;
  assign w_load             = ~w_kill & ~stall_i;

  // Next PC: redirect beats stall, stall beats sequential advance
  always_comb begin
    pc_d = w_pc_plus4;
    if (redirect_valid_i) begin
      pc_d = w_redirect_aligned;
    end else if (stall_i) begin
      pc_d = pc_q;
    end
  end

  // Next IF/ID contents: a kill inserts a bubble but keeps the old PC tags
  always_comb begin
    id_valid_d    = id_valid_q;
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    id_pc4_d      = id_pc4_q;
    fetch_count_d = fetch_count_q;
    if (w_kill) begin
      id_valid_d = 1'b0;
      id_instr_d = NOP_INSTR;
    end else if (w_load) begin
      id_valid_d    = 1'b1;
      id_instr_d    = imem_rdata_i;
      id_pc_d       = pc_q;
      id_pc4_d      = w_pc_plus4;
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  // State registers with synchronous active-low reset overriding all requests
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      pc_q          <= RESET_PC;
      id_valid_q    <= 1'b0;
      id_instr_q    <= NOP_INSTR;
      id_pc_q       <= 32'd0;
      id_pc4_q      <= 32'd0;
      fetch_count_q <= 32'd0;
    end else begin
      pc_q          <= pc_d;
      id_valid_q    <= id_valid_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      id_pc4_q      <= id_pc4_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Outputs come straight from registers; imem_addr is the live PC
  assign imem_addr_o   = pc_q;
  assign id_valid_o    = id_valid_q;
  assign id_instr_o    = id_instr_q;
  assign id_pc_o       = id_pc_q;
  assign id_pc4_o      = id_pc4_q;
  assign fetch_count_o = fetch_count_q;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_stage
// Description : Self-checking bench for if_stage. A transaction-level model
//               tracks the expected stage state; literal checks pin it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_stage;

  localparam logic [31:0] c_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] c_NOP      = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        rv = 1'b0;
  logic [31:0] rpc = 32'd0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic [31:0] fetch_count;

  int tests = 0;
  int fails = 0;

  if_stage #(.RESET_PC(c_RESET_PC), .NOP_INSTR(c_NOP)) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .stall_i          (stall),
    .flush_i          (flush),
    .redirect_valid_i (rv),
    .redirect_pc_i    (rpc),
    .imem_addr_o      (imem_addr),
    .imem_rdata_i     (imem_rdata),
    .id_valid_o       (id_valid),
    .id_instr_o       (id_instr),
    .id_pc_o          (id_pc),
    .id_pc4_o         (id_pc4),
    .fetch_count_o    (fetch_count)
  );

  always #5 clk = ~clk;

  // Instruction memory: word i holds i+1
  function automatic logic [31:0] imem(input logic [31:0] a);
    return (a >> 2) + 32'd1;
  endfunction
  assign imem_rdata = imem(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_init = 1'b0;
  logic [31:0] m_pc, m_instr, m_idpc, m_idpc4, m_cnt;
  logic        m_valid;

  always @(posedge clk) begin
    logic [31:0] fetched_pc;
    if (!reset) begin
      m_init = 1'b1;
      m_pc = c_RESET_PC; m_valid = 1'b0; m_instr = c_NOP;
      m_idpc = 32'd0; m_idpc4 = 32'd0; m_cnt = 32'd0;
    end else if (m_init) begin
      fetched_pc = m_pc;
      if (flush || rv) begin
        m_valid = 1'b0;
        m_instr = c_NOP;
      end else if (!stall) begin
        m_valid = 1'b1;
        m_instr = imem(fetched_pc);
        m_idpc  = fetched_pc;
        m_idpc4 = fetched_pc + 32'd4;
        m_cnt   = m_cnt + 32'd1;
      end
      if (rv)          m_pc = {rpc[31:2], 2'b00};
      else if (!stall) m_pc = fetched_pc + 32'd4;
    end
  end

  // Compare DUT against model every cycle once reset has been seen
  always @(negedge clk) begin
    if (m_init) begin
      chk("imem_addr",   imem_addr,           m_pc);
      chk("id_valid",    {31'd0, id_valid},   {31'd0, m_valid});
      chk("id_instr",    id_instr,            m_instr);
      chk("id_pc",       id_pc,               m_idpc);
      chk("id_pc4",      id_pc4,              m_idpc4);
      chk("fetch_count", fetch_count,         m_cnt);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; stall = 1'b0; flush = 1'b0; rv = 1'b0; rpc = 32'd0;
    cyc(1);
    reset = 1'b1;
  endtask

  typedef struct {
    logic        s;
    logic        f;
    logic        r;
    logic [31:0] t;
  } vec_t;

  vec_t vecs[12] = '{
    '{1'b0, 1'b0, 1'b0, 32'h0},
    '{1'b1, 1'b1, 1'b0, 32'h0},
    '{1'b0, 1'b1, 1'b1, 32'h0000_0102},
    '{1'b0, 1'b0, 1'b0, 32'h0},
    '{1'b1, 1'b0, 1'b0, 32'h0},
    '{1'b0, 1'b0, 1'b1, 32'h0000_0021},
    '{1'b1, 1'b0, 1'b1, 32'h0000_0080},
    '{1'b0, 1'b0, 1'b0, 32'h0},
    '{1'b0, 1'b1, 1'b0, 32'h0},
    '{1'b1, 1'b0, 1'b0, 32'h0},
    '{1'b0, 1'b0, 1'b0, 32'h0},
    '{1'b0, 1'b0, 1'b0, 32'h0}
  };

  initial begin
    #2;
    cyc(2);  // two reset edges
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_instr", id_instr, 32'd0);
    chk("rst_fc",    fetch_count, 32'd0);
    chk("rst_addr",  imem_addr, 32'd0);
    reset = 1'b1;

    // Free run four edges
    cyc(4);
    chk("run_idpc",  id_pc, 32'd12);
    chk("run_instr", id_instr, 32'd4);
    chk("run_fc",    fetch_count, 32'd4);

    // Stall at PC=8
    do_reset();
    cyc(2);
    chk("pre_stall_addr", imem_addr, 32'd8);
    stall = 1'b1;
    cyc(3);
    chk("stall_addr",  imem_addr, 32'd8);
    chk("stall_idpc",  id_pc, 32'd4);
    chk("stall_valid", {31'd0, id_valid}, 32'd1);
    chk("stall_fc",    fetch_count, 32'd2);
    stall = 1'b0;
    cyc(1);
    chk("unstall_idpc", id_pc, 32'd8);

    // Redirect with stall
    stall = 1'b1; rv = 1'b1; rpc = 32'h0000_0043;
    cyc(1);
    chk("redir_addr",  imem_addr, 32'h40);
    chk("redir_valid", {31'd0, id_valid}, 32'd0);
    chk("redir_instr", id_instr, 32'd0);
    stall = 1'b0; rv = 1'b0;
    cyc(1);
    chk("redir_idpc",  id_pc, 32'h40);
    chk("redir_v2",    {31'd0, id_valid}, 32'd1);
    chk("redir_inst2", id_instr, 32'h11);

    // Flush only at PC=16
    do_reset();
    cyc(4);
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    chk("flush_valid", {31'd0, id_valid}, 32'd0);
    chk("flush_instr", id_instr, 32'd0);
    chk("flush_addr",  imem_addr, 32'd20);
    chk("flush_fc",    fetch_count, 32'd4);

    // Redirect to top of address space and wrap
    rv = 1'b1; rpc = 32'hFFFF_FFFC;
    cyc(1);
    rv = 1'b0;
    cyc(1);
    chk("wrap_idpc",  id_pc, 32'hFFFF_FFFC);
    chk("wrap_idpc4", id_pc4, 32'd0);
    chk("wrap_addr",  imem_addr, 32'd0);
    cyc(1);
    chk("wrap_next",  id_pc, 32'd0);

    // Mixed directed vectors, checked by the model
    for (int i = 0; i < 12; i++) begin
      stall = vecs[i].s; flush = vecs[i].f; rv = vecs[i].r; rpc = vecs[i].t;
      cyc(1);
    end
    stall = 1'b0; flush = 1'b0; rv = 1'b0;

    // Mid-run reset at fetch_count=7
    do_reset();
    cyc(7);
    chk("pre_rst_fc", fetch_count, 32'd7);
    reset = 1'b0;
    cyc(1);
    chk("mrst_valid", {31'd0, id_valid}, 32'd0);
    chk("mrst_idpc",  id_pc, 32'd0);
    chk("mrst_fc",    fetch_count, 32'd0);
    chk("mrst_addr",  imem_addr, c_RESET_PC);
    reset = 1'b1;
    cyc(1);
    chk("resume_valid", {31'd0, id_valid}, 32'd1);
    chk("resume_instr", id_instr, 32'd1);
    chk("resume_fc",    fetch_count, 32'd1);

    cyc(1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
